ma_pipeline: RTL
================

# ma_pipeline

Memory-access stage of the 5-stage RV32I pipeline. Consumes the EX/MA register outputs (destination, write-enable, store flag, write-back select, funct3, ALU result, forwarded store data, pc+4) and performs loads and stores on the data-memory port through a ready/request handshake, stalling upstream while memory is busy. Load data is sign/zero-extended and registered with the rest of the control into the MA/WB register. The current ALU result is exposed for EX-stage forwarding.

## Interface
- No parameters; widths fixed at 32-bit data, 5-bit register address.
- `clk` in 1 — pipeline clock, rising edge.
- `reset` in 1 — asynchronous, active-high reset.
- `RegWEn_in`, `MemRW_in` in 1 — from EX/MA; `MemRW_in`=1 means store.
- `WBSel_in` in 2 — 00 mem, 01 ALU, 10 pc+4.
- `funct3_in` in 3 — load/store width and signedness.
- `ALU_Result_in` in 32 — effective address / ALU value.
- `DataB_in` in 32 — store data.
- `pcPlus4_in` in 32; `AddrD_in` in 5.
- `dmem_req` out 1; `dmem_we` out 1; `dmem_addr` out 32 (bits[1:0]=0); `dmem_wdata` out 32; `dmem_wstrb` out 4.
- `dmem_ready` in 1; `dmem_rdata` in 32.
- `stall_ma` out 1 — freezes PC, IF/ID, ID/EX, EX/MA.
- `ALU_Result_MA` out 32 — combinational copy of `ALU_Result_in` for forwarding.
- `RegWEn_out` out 1; `WBSel_out` out 2; `AddrD_out` out 5; `ALU_Result_out`, `MemData_out`, `pcPlus4_out` out 32 — MA/WB register.
- `misalign_out` out 1 — registered; present only with `MA_MISALIGN_TRAP_EN`.

## Operation
- Access = `MemRW_in` | (`RegWEn_in` & `WBSel_in`==00). Otherwise pass-through, no `dmem_req`.
- Store: SB (000) strobe `0001<<addr[1:0]`, wdata = byte replicated ×4; SH (001) strobe `0011<<{addr[1],0}`, half replicated ×2; SW (010) strobe 1111. Other funct3 treated as SW.
- Load: lane selected by `addr[1:0]`; LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
- FSM IDLE/WAIT. IDLE: access → `dmem_req`=1; if `dmem_ready` same cycle, complete, stay IDLE; else → WAIT. WAIT: `dmem_req` held with stable addr/we/wdata/wstrb; on `dmem_ready`=1 complete → IDLE.
- `stall_ma` = access & ~`dmem_ready` (combinational, both states).
- On stall edges the MA/WB register loads a bubble: `RegWEn_out`=0, others hold.
- On completion/pass-through edges: MA/WB loads inputs; `MemData_out` = extended load data (0 for non-load).

## Timing
- Reset (async): FSM IDLE, `dmem_req`=0, all MA/WB outputs 0, `misalign_out`=0. Reset mid-WAIT abandons the request in the same cycle.
- Non-memory op / zero-wait memory: 1-cycle latency, no stall.
- N-wait memory (`dmem_ready` low N cycles): `stall_ma` high N cycles, result registered at edge where ready sampled high.
- `dmem_ready` while `dmem_req`=0 ignored.
- Store completion writes nothing back unless `RegWEn_in` (never for valid code).

## Configuration
- `MA_MISALIGN_TRAP_EN` defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]≠0 issue no `dmem_req`, no stall; MA/WB registers a bubble (`RegWEn_out`=0) and `misalign_out`=1 for one cycle.
- Undefined: low address bits beyond access width ignored (forced alignment); `misalign_out` port absent.

## Structure
- Shared package: WBSel encodings (WB_MEM=00, WB_ALU=01, WB_PC4=10), funct3 load/store constants, FSM state enum.
- One sub-module `load_ext` (combinational lane select + sign/zero extension); strobe/wdata generation inline.

## Test plan
- ALU op, WBSel=01, ALU_Result_in=0x1234, AddrD=5, ready=1 → next cycle RegWEn_out=1, ALU_Result_out=0x1234, no dmem_req, no stall.
- SB addr=0x103, DataB=0xAABBCCDD, ready=1 → dmem_addr=0x100, wstrb=1000, wdata=0xDDDDDDDD, we=1.
- LB addr=0x101, rdata=0x00008000 → MemData_out=0xFFFFFF80; LBU same → 0x00000080; LH addr=0x102, rdata=0x80010000 → 0xFFFF8001.
- LW with ready low 3 cycles → stall_ma high 3 cycles, req held, bubbles into WB, data registered on 4th edge.
- Reset asserted in WAIT → dmem_req and all outputs 0 immediately, FSM IDLE after release.
- With MA_MISALIGN_TRAP_EN: LW addr=0x102 → no req, RegWEn_out=0, misalign_out=1 one cycle.

Source files
------------

// File: rtl/ma_pipeline_pkg.sv
// Shared types and encodings for the RV32I memory-access stage.
package ma_pipeline_pkg;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {StIdle, StWait} ma_state_e;

endpackage

// File: rtl/ma_pipeline_if.sv
// Data-memory request/ready port used by the memory-access stage.
interface ma_pipeline_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input req, we, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/ma_pipeline_load_ext.sv
// Load lane select and sign/zero extension; half lanes use addr[1] only.
module ma_pipeline_load_ext
  import ma_pipeline_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    unique case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/ma_pipeline.sv
// RV32I memory-access stage with MA/WB register. Define MA_MISALIGN_TRAP_EN to turn
// misaligned accesses into bubbles flagged on misalign_out instead of forcing alignment.
module ma_pipeline
  import ma_pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWEn_in,
  input  logic        MemRW_in,
  input  logic [1:0]  WBSel_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] ALU_Result_in,
  input  logic [31:0] DataB_in,
  input  logic [31:0] pcPlus4_in,
  input  logic [4:0]  AddrD_in,
  ma_pipeline_if.master dmem,
  output logic        stall_ma,
  output logic [31:0] ALU_Result_MA,
  output logic        RegWEn_out,
  output logic [1:0]  WBSel_out,
  output logic [4:0]  AddrD_out,
  output logic [31:0] ALU_Result_out,
  output logic [31:0] MemData_out,
`ifdef MA_MISALIGN_TRAP_EN
  output logic        misalign_out,
`endif
  output logic [31:0] pcPlus4_out
);

  ma_state_e   state_q, state_d;
  logic        access, access_ok, misalign, stall_int, is_load;
  logic [31:0] load_data;
  logic [1:0]  lo;

  assign lo       = ALU_Result_in[1:0];
  assign access   = MemRW_in | (RegWEn_in & (WBSel_in == WB_MEM));
  assign is_load  = access & ~MemRW_in;

`ifdef MA_MISALIGN_TRAP_EN
  logic mis_raw;
  logic misalign_q;

  // Unknown store widths are treated as words, so they get the word alignment check.
  always_comb begin
    mis_raw = 1'b0;
    if (MemRW_in) begin
      case (funct3_in)
        F3_B:    mis_raw = 1'b0;
        F3_H:    mis_raw = lo[0];
        default: mis_raw = |lo;
      endcase
    end else begin
      case (funct3_in)
        F3_H, F3_HU: mis_raw = lo[0];
        F3_W:        mis_raw = |lo;
        default:     mis_raw = 1'b0;
      endcase
    end
  end
  assign misalign = access & mis_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign;
  end
  assign misalign_out = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign access_ok = access & ~misalign;
  assign stall_int = access_ok & ~dmem.ready;

  // Reset gates the request and stall so an in-flight access is dropped immediately.
  assign dmem.req      = access_ok & ~reset;
  assign stall_ma      = stall_int & ~reset;
  assign dmem.we       = MemRW_in;
  assign dmem.addr     = {ALU_Result_in[31:2], 2'b00};
  assign ALU_Result_MA = ALU_Result_in;

  always_comb begin
    dmem.wstrb = 4'b0000;
    dmem.wdata = DataB_in;
    if (MemRW_in) begin
      case (funct3_in)
        F3_B: begin
          dmem.wstrb = 4'b0001 << lo;
          dmem.wdata = {4{DataB_in[7:0]}};
        end
        F3_H: begin
          dmem.wstrb = 4'b0011 << {lo[1], 1'b0};
          dmem.wdata = {2{DataB_in[15:0]}};
        end
        default: dmem.wstrb = 4'b1111;
      endcase
    end
  end

  ma_pipeline_load_ext load_ext (
    .funct3  (funct3_in),
    .addr_lo (lo),
    .rdata   (dmem.rdata),
    .data    (load_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (access_ok && !dmem.ready) state_d = StWait;
      StWait: if (dmem.ready || !access_ok) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWEn_out     <= 1'b0;
      WBSel_out      <= 2'b00;
      AddrD_out      <= 5'd0;
      ALU_Result_out <= 32'h0;
      MemData_out    <= 32'h0;
      pcPlus4_out    <= 32'h0;
    end else if (stall_int || misalign) begin
      RegWEn_out <= 1'b0;
    end else begin
      RegWEn_out     <= RegWEn_in;
      WBSel_out      <= WBSel_in;
      AddrD_out      <= AddrD_in;
      ALU_Result_out <= ALU_Result_in;
      MemData_out    <= is_load ? load_data : 32'h0;
      pcPlus4_out    <= pcPlus4_in;
    end
  end

endmodule
